// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds field widths, the Tnew/Tuse sentinels, mult/div latency defaults,
// the bubble encoding, the E/M scoreboard entry and the hazard helpers.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 3;
  localparam int unsigned TUSE_W = 2;

  // All-ones Tnew marks a bubble; real instructions never exceed 2.
  localparam logic [TNEW_W-1:0] TNEW_MAX  = '1;
  // Tuse value meaning "operand not read".
  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Instruction word loaded into ID/EX on flush.
  localparam logic [31:0] BUBBLE_INSTR = 32'h0;

  // One scoreboard slot: destination register and cycles until its result exists.
  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [TNEW_W-1:0] tnew;
  } sb_entry_t;

  // True when a D-stage source must wait for a producer in E or M.
  function automatic logic src_hazard(input logic [REG_W-1:0]  src,
                                      input logic [TUSE_W-1:0] tuse,
                                      input sb_entry_t         e,
                                      input sb_entry_t         m);
    logic hit_e;
    logic hit_m;
    hit_e = (e.a3 == src) && (TNEW_W'(tuse) < e.tnew);
    hit_m = (m.a3 == src) && (TNEW_W'(tuse) < m.tnew);
    return (src != '0) && (hit_e || hit_m);
  endfunction

  // Tnew one stage later; saturates at zero.
  function automatic logic [TNEW_W-1:0] tnew_step(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Mult/div occupancy counter.
// Ports: clk, reset (async, active-high), start (issue accepted into E),
// div_sel (1 = div latency, 0 = mult latency), busy (counter nonzero, combinational).
module hazard_ctrl_md_busy_cnt #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div_sel,
  output logic busy
);

  localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Load on an accepted issue, otherwise count down to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= div_sel ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Tracks (A3, Tnew) of the E and M instructions, compares against the D-stage
// Tuse values and the mult/div busy state, and drives the front-end enables.
// Ports: clk, reset (async, active-high); D-stage inputs rs_D, rt_D, tuse_rs_D,
// tuse_rt_D, a3_D, tnew_D, md_start_D, md_div_D, md_use_D; outputs en_F, en_D,
// flush_E, md_busy (all combinational, zero latency).
// Optional macro HAZARD_STAT_EN adds stall_cnt and md_stall_cnt (32-bit counters).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  rs_D,
  input  logic [REG_W-1:0]  rt_D,
  input  logic [TUSE_W-1:0] tuse_rs_D,
  input  logic [TUSE_W-1:0] tuse_rt_D,
  input  logic [REG_W-1:0]  a3_D,
  input  logic [TNEW_W-1:0] tnew_D,
  input  logic              md_start_D,
  input  logic              md_div_D,
  input  logic              md_use_D,
  output logic              en_F,
  output logic              en_D,
  output logic              flush_E,
`ifdef HAZARD_STAT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       md_stall_cnt,
`endif
  output logic              md_busy
);

  sb_entry_t sb_E;
  sb_entry_t sb_M;
  logic      hz_rs;
  logic      hz_rt;
  logic      hz_md;
  logic      stall;

  // Hazard detection against the scoreboard and the mult/div unit.
  always_comb begin
    hz_rs = src_hazard(rs_D, tuse_rs_D, sb_E, sb_M);
    hz_rt = src_hazard(rt_D, tuse_rt_D, sb_E, sb_M);
    hz_md = md_use_D && md_busy;
    stall = hz_rs || hz_rt || hz_md;
  end

  assign en_F    = !stall;
  assign en_D    = !stall;
  assign flush_E = stall;

  // Scoreboard advance; a stall injects a bubble (no destination) into E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_E <= '0;
      sb_M <= '0;
    end else begin
      if (stall) begin
        sb_E <= '0;
      end else begin
        sb_E.a3   <= a3_D;
        sb_E.tnew <= tnew_D;
      end
      sb_M.a3   <= sb_E.a3;
      sb_M.tnew <= tnew_step(sb_E.tnew);
    end
  end

  hazard_ctrl_md_busy_cnt #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_D && !stall),
    .div_sel(md_div_D),
    .busy   (md_busy)
  );

`ifdef HAZARD_STAT_EN
  // Stall cycle statistics; both counters wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (hz_md) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall and flush controller for the 5-stage MIPS pipeline.
- Tracks the destination register (A3) and Tnew of every instruction in E and M, and compares them against the Tuse of the instruction in D.
- Owns the mult/div busy counter.
- Drives the PC enable, the IF/ID enable, and the ID/EX bubble-insert (flush) that sequence the ID/EX pipeline register.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu issues into E
- DIV_CYCLES, 10, busy cycles after div/divu issues into E
- TNEW_W, 3, width of Tnew fields; all-ones (Tnew_MAX = 7) is legal only for bubbles

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- rs_D  in  5  D-stage rs field
- rt_D  in  5  D-stage rt field
- tuse_rs_D  in  2  cycles until rs is consumed; 3 = not used
- tuse_rt_D  in  2  same for rt
- a3_D  in  5  D-stage destination register; 0 = none
- tnew_D  in  TNEW_W  Tnew of the D instruction as it will enter E
- md_start_D  in  1  D instruction is mult/multu/div/divu
- md_div_D  in  1  1 = div/divu, 0 = mult/multu (valid with md_start_D)
- md_use_D  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div
- en_F  out  1  PC write enable
- en_D  out  1  IF/ID write enable
- flush_E  out  1  ID/EX loads bubble (Instr=0, Tnew=Tnew_MAX)
- md_busy  out  1  mult/div counter nonzero

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - reset is asynchronous and active-high; all internal state clears immediately on assertion.
- Internal state and reset values:
  - a3_E = 0, tnew_E = 0
  - a3_M = 0, tnew_M = 0
  - md_cnt = 0
- Hazard check (combinational):
  - hz_rs = (rs_D != 0) && ((a3_E == rs_D && tuse_rs_D < tnew_E) || (a3_M == rs_D && tuse_rs_D < tnew_M)).
  - hz_rt is the same expression using rt_D and tuse_rt_D.
  - tuse = 3 never stalls, because tnew never exceeds 2 for a real instruction.
- Mult/div check: hz_md = md_use_D && md_busy.
- stall = hz_rs | hz_rt | hz_md.
- Outputs (combinational, zero latency):
  - en_F = en_D = !stall
  - flush_E = stall
  - md_busy = (md_cnt != 0)
  - During reset: en_F = 1, en_D = 1, flush_E = 0, md_busy = 0.
- Scoreboard advance (every posedge):
  - E stage:
    - If stall: a3_E <= 0, tnew_E <= 0 (bubble enters E).
    - Else: a3_E <= a3_D, tnew_E <= tnew_D.
  - M stage: a3_M <= a3_E, tnew_M <= (tnew_E == 0) ? 0 : tnew_E - 1. Saturating; never wraps.
  - Instructions in W need no check; the register file writes first-half and forwards.
- md_cnt updates at each posedge:
  - If md_start_D && !stall: load MULT_CYCLES or DIV_CYCLES, chosen by md_div_D.
  - Else if md_cnt != 0: decrement.
  - A new start cannot collide with a busy counter: md_start_D implies md_use_D, so it stalls while busy.
- Simultaneous hazards:
  - Any source of stall gives exactly one bubble per cycle.
  - Priority is irrelevant; all sources share the single stall signal.
- Reset mid-stall: state clears asynchronously; the first cycle after release has no hazards.
- The pipeline's D instruction is retained by en_D = 0; the D inputs hold stable during a stall.

Optional Feature:
- Macro: HAZARD_STAT_EN
- Defined:
  - Adds output stall_cnt (32 bits).
  - Increments on every posedge where stall = 1; wraps 0xFFFFFFFF -> 0.
  - Cleared by reset.
  - Adds output md_stall_cnt (32 bits), which counts cycles with hz_md only.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Tnew_MAX and TUSE_NONE (= 3)
  - MULT_CYCLES and DIV_CYCLES defaults
  - Bubble encoding (Instr 32'h0)
- Sub-module md_busy_cnt isolates the load/decrement counter and md_busy.

Test Plan:
- Load-use on ALU op: lw $1 (tnew_D = 2), then addu $2,$1,$3 (tuse_rs = 1). Required: stall exactly 1 cycle, flush_E = 1 in that cycle, en_F = en_D = 0.
- Load-use on branch: lw $1, then beq $1,$0 (tuse_rs = 0). Required: stall 2 consecutive cycles, then proceed.
- ALU into branch: addu $1 (tnew_D = 1), then beq $1 (tuse = 0). Required: 1 stall cycle. Repeat with rs = $0: required 0 stalls.
- Mult/div occupancy: div (md_div_D = 1), then mflo immediately. Required: md_busy high for 10 cycles, mflo stalled 10 cycles. With mult: 5 cycles.
- Reset during a stall: assert reset asynchronously mid-stall. Required: en_F = 1, flush_E = 0, md_busy = 0 before the next clock edge.
- HAZARD_STAT_EN: run the load-use-on-branch sequence. Required: stall_cnt = 2.
